// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial datapath stages.
// Holds the default word width used by the serial arithmetic stages and the
// occupancy-state encoding used by the deserializer output buffer.
package serial_pkg;

    // Default frame width shared with the serial arithmetic stages.
    localparam int SERIAL_WORD_W = 4;

    // Buffer control state, a pure function of occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PART  = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    // Maps an occupancy count onto the buffer control state.
    function automatic occ_state_e occ_of(input int unsigned cnt, input int unsigned depth);
        occ_state_e s;
        if (cnt == 0) begin
            s = EMPTY;
        end else if (cnt >= depth) begin
            s = FULL;
        end else begin
            s = PART;
        end
        return s;
    endfunction

endpackage

// File: rtl/serial_deser_if.sv
// Stream bundle for the deserializer: serial bit input and parallel word output.
// Ports: in_valid/in_bit (serial side), out_data/out_valid/out_ready (word side).
// master = producer/consumer environment, slave = deserializer.
interface serial_deser_if
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WORD_W
);
    logic             in_valid;
    logic             in_bit;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid,
        output in_bit,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/sync_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO with occupancy-derived EMPTY/PART/FULL control.
// Latency: a pushed word is visible on pop_data the cycle after the push edge.
// Backpressure: push while FULL is ignored unless a pop happens in the same cycle.
// Ports: clk, reset (sync, active-high), push/push_data, pop/pop_data,
//        full, empty, count (0..DEPTH).
// When empty, pop_data holds the most recently popped word (0 after reset).
module sync_fifo
    import serial_pkg::*;
#(
    parameter  int WIDTH = SERIAL_WORD_W,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_n;
    logic [WIDTH-1:0] last_q;
    occ_state_e       state_q;
    occ_state_e       state_n;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps this correct for DEPTH == 1 as well.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (state_q != EMPTY);
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign do_push = push && ((state_q != FULL) || do_pop);

    always_comb begin
        count_n = count_q;
        state_n = state_q;
        case ({do_push, do_pop})
            2'b10:   count_n = count_q + 1'b1;
            2'b01:   count_n = count_q - 1'b1;
            default: count_n = count_q;
        endcase
        state_n = occ_of(32'(count_n), 32'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            count_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                last_q <= mem[rd_ptr];
            end
        end
    end

    // Storage carries no reset; contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = (state_q == EMPTY) ? last_q : mem[rd_ptr];
    assign full     = (state_q == FULL);
    assign empty    = (state_q == EMPTY);
    assign count    = count_q;

endmodule

// File: rtl/serial_deser.sv
// Purpose: reassembles LSB-first WIDTH-bit serial frames into words and buffers them.
// Latency: word appears on out_data/out_valid the cycle after its last bit's edge.
// Backpressure: out_ready stalls the buffer; a word completing into a full buffer
//               with no pop is dropped and latches the sticky overflow flag.
// Ports: clk, reset (sync, active-high), bus (serial_deser_if.slave: in_valid,
//        in_bit, out_data, out_valid, out_ready), overflow, clr_overflow, frame_pos.
// Optional SERIAL_DESER_STATS_EN adds word_count (popped, wrapping) and
// drop_count (dropped, saturating).
module serial_deser
    import serial_pkg::*;
#(
    parameter  int WIDTH = SERIAL_WORD_W,
    parameter  int DEPTH = 2,
    localparam int POS_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    serial_deser_if.slave    bus,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic [POS_W-1:0] frame_pos
`ifdef SERIAL_DESER_STATS_EN
    ,
    output logic [15:0]      word_count,
    output logic [7:0]       drop_count
`endif
);

    logic [POS_W-1:0] pos_q;
    // The top bit never needs storing: it arrives on in_bit in the completion cycle.
    logic [WIDTH-2:0] asm_q;
    logic             frame_done;
    logic [WIDTH-1:0] word;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [WIDTH-1:0] fifo_data;
    logic             overflow_q;

    assign frame_done = bus.in_valid && (pos_q == POS_W'(WIDTH - 1));
    assign word       = {bus.in_bit, asm_q};
    assign pop        = !fifo_empty && bus.out_ready;
    assign drop       = frame_done && fifo_full && !pop;

    // Frame alignment advances only on valid bits, so stalls and drops never shift it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= '0;
            asm_q <= '0;
        end else if (bus.in_valid) begin
            pos_q <= (pos_q == POS_W'(WIDTH - 1)) ? '0 : pos_q + 1'b1;
            for (int i = 0; i < WIDTH - 1; i++) begin
                if (pos_q == POS_W'(i)) begin
                    asm_q[i] <= bus.in_bit;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (frame_done),
        .push_data (word),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Set has priority over clear so a drop is never lost to a concurrent clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clr_overflow) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef SERIAL_DESER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            word_count <= '0;
            drop_count <= '0;
        end else begin
            if (clr_overflow) begin
                word_count <= pop ? 16'd1 : 16'd0;
            end else if (pop) begin
                word_count <= word_count + 16'd1;
            end
            if (clr_overflow) begin
                drop_count <= drop ? 8'd1 : 8'd0;
            end else if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
`endif

    assign bus.out_data  = fifo_data;
    assign bus.out_valid = (fifo_count != '0);
    assign overflow      = overflow_q;
    assign frame_pos     = pos_q;

endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser (WIDTH=4, DEPTH=2): directed serial frames, expected
// words queued at issue time and compared by a monitor on every handshake.
module tb_serial_deser;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr_overflow;
    logic       overflow;
    logic [1:0] frame_pos;
`ifdef SERIAL_DESER_STATS_EN
    logic [15:0] word_count;
    logic [7:0]  drop_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    always #5 clk = ~clk;

    serial_deser_if #(.WIDTH(4)) bus ();

    serial_deser #(
        .WIDTH (4),
        .DEPTH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .frame_pos    (frame_pos)
`ifdef SERIAL_DESER_STATS_EN
        ,
        .word_count   (word_count),
        .drop_count   (drop_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every accepted word must match the head of the queue.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("word", 32'(bus.out_data), 32'(mon_exp));
            end
        end
    end

    // One cycle of input drive, applied just after the rising edge.
    task automatic drive(input logic v, input logic b, input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_bit    = b;
        bus.out_ready = rdy;
        clr_overflow  = clr;
    endtask

    task automatic send_word(input logic [3:0] w, input logic rdy, input logic expect_out);
        if (expect_out) exp_q.push_back(w);
        for (int i = 0; i < 4; i++) drive(1'b1, w[i], rdy, 1'b0);
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.out_ready = 1'b0;
        clr_overflow  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_pos", 32'(frame_pos), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);

        // Single word 6 (bits 0,1,1,0), consumer always ready.
        send_word(4'h6, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_valid_after", 32'(bus.out_valid), 32'd0);

        // Fill with 3, A; F is dropped.
        send_word(4'h3, 1'b0, 1'b1);
        send_word(4'hA, 1'b0, 1'b1);
        send_word(4'hF, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_valid", 32'(bus.out_valid), 32'd1);
        check("t2_head_stable", 32'(bus.out_data), 32'h3);
        check("t2_frame_pos", 32'(frame_pos), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("t2_empty", 32'(bus.out_valid), 32'd0);
        check("t2_overflow_sticky", 32'(overflow), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("t2_cleared", 32'(overflow), 32'd0);

        // Full buffer, pop coincides with completion of 9 (bits 1,0,0,1).
        send_word(4'h5, 1'b0, 1'b1);
        send_word(4'h7, 1'b0, 1'b1);
        exp_q.push_back(4'h9);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("t3_no_overflow", 32'(overflow), 32'd0);
        drain("t3_drain", 10);
        @(negedge clk);
        check("t3_empty", 32'(bus.out_valid), 32'd0);

        // Word C (bits 0,0,1,1) with a 3-cycle stall after two bits.
        exp_q.push_back(4'hC);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            check("t4_stall_pos", 32'(frame_pos), 32'd2);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("t4_valid", 32'(bus.out_valid), 32'd1);
        drain("t4_drain", 10);

        // Buffered word B and a partial frame are both discarded by reset.
        send_word(4'hB, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t5_frame_pos", 32'(frame_pos), 32'd0);
        check("t5_overflow", 32'(overflow), 32'd0);
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        send_word(4'h1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drain("t5_drain", 10);

        // Concurrent drop and clear: set wins; a later clear alone takes effect.
        send_word(4'h2, 1'b0, 1'b1);
        send_word(4'h4, 1'b0, 1'b1);
        send_word(4'h8, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_overflow", 32'(overflow), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_set_wins", 32'(overflow), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_clear", 32'(overflow), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drain("t6_drain", 10);
        @(negedge clk);
        check("t6_empty", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
